fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
// - Shares the single write port of the sync FIFO among NUM_REQ producers.
// - Grants one producer per cycle, round-robin; registers and drives fifo_wr_en/fifo_data_in.
// - Throttles on full/almostfull so the FIFO never sees a write while full.
// - Sits between producer agents and the FIFO DUT modport; the FIFO read side is untouched.
// PARAMETERS
// - FIFO_WIDTH  16  data width per producer and to the FIFO
// - NUM_REQ     4   number of producers (2..8)
// - ID_W        $clog2(NUM_REQ)  width of grant_id (derived, do not override)
// PORTS
// - clk              in   1                    rising-edge clock
// - rst              in   1                    synchronous, active-high reset
// - req              in   NUM_REQ              per-producer request; held until gnt
// - req_data         in   NUM_REQ*FIFO_WIDTH   producer k data at [k*FIFO_WIDTH +: FIFO_WIDTH]
// - gnt              out  NUM_REQ              one-hot pulse: req_data[k] sampled this cycle
// - grant_id         out  ID_W                 index of last granted producer
// - fifo_full        in   1                    FIFO full flag
// - fifo_almostfull  in   1                    FIFO almostfull flag (depth-1 entries)
// - fifo_wr_ack      in   1                    FIFO write acknowledge (cycle after wr_en)
// - fifo_wr_en       out  1                    registered write enable to FIFO
// - fifo_data_in     out  FIFO_WIDTH           registered write data to FIFO
// - busy             out  1                    FSM not in IDLE
// - err              out  1                    sticky ack-mismatch flag (see CONFIGURATION)
// BEHAVIOUR
// - Reset: gnt=0, grant_id=NUM_REQ-1, fifo_wr_en=0, fifo_data_in=0, busy=0, err=0, FSM=IDLE.
// - Reset mid-operation: any in-flight write is dropped; no gnt in the reset cycle.
// - ok = !fifo_full && !(fifo_almostfull && fifo_wr_en).
// - Round-robin: search starts at grant_id+1 mod NUM_REQ; first k with req[k] wins.
// - Grant cycle (ok && |req):
//   - gnt[k]=1 combinationally.
//   - Next edge: fifo_wr_en=1, fifo_data_in=req_data[k], grant_id=k.
// - Latency: gnt to FIFO write is 1 cycle; max 1 grant per cycle; back-to-back grants allowed.
// - A producer holding req gets a grant within NUM_REQ grant slots (starvation-free).
// - No grant: fifo_wr_en=0 next cycle; fifo_data_in holds its value.
// - FSM:
//   - IDLE  -> RUN   when |req && ok
//   - IDLE  -> STALL when |req && !ok
//   - RUN   -> STALL when !ok && |req
//   - RUN   -> IDLE  when !|req
//   - STALL -> RUN   when ok && |req
//   - STALL -> IDLE  when !|req
//   - gnt only in IDLE/RUN with ok; busy = (state != IDLE).
// - Simultaneous FIFO read while full: no grant that cycle (conservative); grant next cycle once full clears.
// - req dropped without gnt: legal, no side effects. gnt[k] never asserts without req[k].
// - grant_id wraps NUM_REQ-1 -> 0.
// CONFIGURATION
// - Macro FIFO_WR_ARB_ACK_CHK_EN.
// - Defined:
//   - 1-cycle delayed copy of fifo_wr_en is compared with fifo_wr_ack.
//   - Mismatch (expected ack missing, or unexpected ack) sets err; err cleared only by rst.
// - Undefined: err tied 0; fifo_wr_ack ignored; no checker logic.
// TESTING
// - Reset: assert rst 2 cycles with req=4'b1111 -> gnt=0, fifo_wr_en=0, grant_id=3, err=0.
// - Round-robin: req=4'b1111 held, FIFO empty -> gnt order 0,1,2,3,0;
//   fifo_data_in follows one cycle later.
// - Throttle: FIFO depth 8, reads off, req[2] held with data 16'hA5A5:
//   - exactly 8 writes, then STALL, gnt=0, no overflow.
//   - One read -> one further grant.
// - Sparse: req=4'b0100 after a grant to 3 -> grant 2 next cycle;
//   then req=4'b1001 -> grant 3 before 0.
// - Mid-op reset: rst during fifo_wr_en=1 -> next cycle fifo_wr_en=0, FSM=IDLE, grant_id=3.
// - ACK_CHK_EN defined: force fifo_wr_ack=0 after a write -> err=1 next cycle, stays 1 until rst.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin share of one sync-FIFO write port among NUM_REQ producers (FIFO_WR_ARB_ACK_CHK_EN adds a sticky write-ack checker).
// Latency: gnt is combinational in the grant cycle, fifo_wr_en/fifo_data_in are registered one cycle later; at most one grant per cycle.
// Backpressure: no grant while full or almostfull with a write in flight; the cycle that leaves STALL never grants.
module fifo_wr_arbiter #(
  parameter  int FIFO_WIDTH = 16,
  parameter  int NUM_REQ    = 4,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [ID_W-1:0]               grant_id,
  input  logic                          fifo_full,
  input  logic                          fifo_almostfull,
  input  logic                          fifo_wr_ack,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  output logic                          busy,
  output logic                          err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  ok;
  logic                  any_req;
  logic                  grant;
  logic                  hi_vld;
  logic [ID_W-1:0]       hi_id;
  logic [ID_W-1:0]       lo_id;
  logic [ID_W-1:0]       win_id;
  logic [FIFO_WIDTH-1:0] win_data;

  // A write already registered on fifo_wr_en will consume the last free slot.
  assign ok      = !fifo_full && !(fifo_almostfull && fifo_wr_en);
  assign any_req = |req;

  // Lowest requester above grant_id wins, else wrap to the lowest requester overall.
  always_comb begin
    hi_vld = 1'b0;
    hi_id  = '0;
    lo_id  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        lo_id = ID_W'(k);
        if (k > int'(grant_id)) begin
          hi_vld = 1'b1;
          hi_id  = ID_W'(k);
        end
      end
    end
    win_id   = hi_vld ? hi_id : lo_id;
    win_data = req_data[win_id*FIFO_WIDTH +: FIFO_WIDTH];
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        grant = any_req && ok;
        if (any_req) state_nxt = ok ? RUN : STALL;
      end
      RUN: begin
        grant = any_req && ok;
        if (!any_req)  state_nxt = IDLE;
        else if (!ok)  state_nxt = STALL;
      end
      STALL: begin
        if (!any_req)  state_nxt = IDLE;
        else if (ok)   state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) grant = 1'b0;
  end

  assign gnt  = grant ? (NUM_REQ'(1) << win_id) : '0;
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      grant_id     <= ID_W'(NUM_REQ - 1);
      fifo_wr_en   <= 1'b0;
      fifo_data_in <= '0;
    end else begin
      state      <= state_nxt;
      fifo_wr_en <= grant;
      if (grant) begin
        grant_id     <= win_id;
        fifo_data_in <= win_data;
      end
    end
  end

`ifdef FIFO_WR_ARB_ACK_CHK_EN
  logic wr_en_d;
  logic err_q;

  // Sampled through reset too: a write issued in the reset cycle still lands and is acked.
  always_ff @(posedge clk) begin
    wr_en_d <= fifo_wr_en;
  end

  always_ff @(posedge clk) begin
    if (rst)                         err_q <= 1'b0;
    else if (wr_en_d != fifo_wr_ack) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  logic unused_ack;
  assign unused_ack = fifo_wr_ack;
  assign err        = 1'b0;
`endif

endmodule
